// File: rtl/stacker_matrix_scan_if.sv
// Display bus between the stacker game core and the LED matrix scanner.
// master: game-core side (drives frame and brightness).
// slave:  scanner side (drives the matrix row/column lines and status).
interface stacker_matrix_scan_if;
  logic [63:0] game_display;
  logic [2:0]  brightness;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic [2:0]  scan_row;

  modport master (
    output game_display, brightness,
    input  row_sel, col_data, frame_done, scan_row
  );

  modport slave (
    input  game_display, brightness,
    output row_sel, col_data, frame_done, scan_row
  );
endinterface

// File: rtl/stacker_matrix_scan.sv
// stacker_matrix_scan: time-multiplexes the 64-bit game frame onto an 8x8
// LED matrix, one row at a time with a dark blanking gap before every row.
// The frame is snapshotted once per scan so mid-scan updates never tear.
// Optional PWM dimming is enabled by defining STACKER_SCAN_DIM_EN.
module stacker_matrix_scan #(
  parameter int unsigned ROW_CYCLES     = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  stacker_matrix_scan_if.slave   disp
);

  localparam int unsigned MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0] ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       row_idx, row_idx_n;
  logic [63:0]      frame_buf, frame_buf_n;
  logic [7:0]       row_sel_q, row_sel_n;
  logic [7:0]       col_data_q, col_data_n;
  logic             frame_done_q, frame_done_n;
  logic             snap;
  logic             lit;
  logic [7:0]       row_pat;

  // Next-state: dwell counting, row advance, frame snapshot and end-of-frame strobe.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + CNT_W'(1);
    row_idx_n    = row_idx;
    frame_buf_n  = frame_buf;
    frame_done_n = 1'b0;
    snap         = 1'b0;
    unique case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = S_DRIVE;
          cnt_n   = '0;
          if (row_idx == 3'd0) begin
            snap        = 1'b1;
            frame_buf_n = disp.game_display;
          end
        end
      end
      S_DRIVE: begin
        if (cnt == ROW_LAST) begin
          state_n      = S_BLANK;
          cnt_n        = '0;
          row_idx_n    = row_idx + 3'd1;
          frame_done_n = (row_idx == 3'd7);
        end
      end
      default: begin
        state_n = S_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef STACKER_SCAN_DIM_EN
  logic [2:0] pwm_cnt, pwm_n;
  logic [2:0] bright_lat, bright_n;

  // PWM phase restarts on each DRIVE entry; brightness is captured with the frame.
  always_comb begin
    pwm_n    = pwm_cnt;
    bright_n = bright_lat;
    if (state == S_BLANK && state_n == S_DRIVE) begin
      pwm_n = '0;
    end else if (state == S_DRIVE) begin
      pwm_n = pwm_cnt + 3'd1;
    end
    if (snap) begin
      bright_n = disp.brightness;
    end
    lit = (pwm_n <= bright_n);
  end

  // PWM counter and latched brightness registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt    <= '0;
      bright_lat <= '0;
    end else begin
      pwm_cnt    <= pwm_n;
      bright_lat <= bright_n;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^disp.brightness;
  assign lit = 1'b1;
`endif

  // Outputs are computed from the next state so the registered lines line up
  // with the state they describe; the snapshot row uses the incoming frame.
  always_comb begin
    row_pat    = frame_buf_n[{row_idx_n, 3'b000} +: 8];
    row_sel_n  = ROW_IDLE;
    col_data_n = '0;
    if (state_n == S_DRIVE) begin
      row_sel_n  = (8'h01 << row_idx_n) ^ ROW_IDLE;
      col_data_n = lit ? row_pat : 8'h00;
    end
  end

  // State, counters, frame buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_BLANK;
      cnt          <= '0;
      row_idx      <= '0;
      frame_buf    <= '0;
      row_sel_q    <= ROW_IDLE;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      row_idx      <= row_idx_n;
      frame_buf    <= frame_buf_n;
      row_sel_q    <= row_sel_n;
      col_data_q   <= col_data_n;
      frame_done_q <= frame_done_n;
    end
  end

  assign disp.row_sel    = row_sel_q;
  assign disp.col_data   = col_data_q;
  assign disp.frame_done = frame_done_q;
  assign disp.scan_row   = row_idx;

endmodule

// File: tb/tb_stacker_matrix_scan.sv
// Self-checking bench for stacker_matrix_scan: three instances (active-high,
// active-low rows, long rows) checked against a timeline reference model.
module tb_stacker_matrix_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] gd  = '0;
  logic [2:0]  br  = '0;
  int          t   = 0;
  int          errors = 0;
  int          checks = 0;

  logic [63:0] gd_hist [0:1023];
  logic [2:0]  br_hist [0:1023];

  always #5 clk = ~clk;

  stacker_matrix_scan_if if_a ();
  stacker_matrix_scan_if if_l ();
  stacker_matrix_scan_if if_w ();

  assign if_a.game_display = gd;
  assign if_a.brightness   = br;
  assign if_l.game_display = gd;
  assign if_l.brightness   = br;
  assign if_w.game_display = gd;
  assign if_w.brightness   = br;

  stacker_matrix_scan #(.ROW_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b0))
    dut_a (.clk(clk), .rst(rst), .disp(if_a));
  stacker_matrix_scan #(.ROW_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b1))
    dut_l (.clk(clk), .rst(rst), .disp(if_l));
  stacker_matrix_scan #(.ROW_CYCLES(16), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b0))
    dut_w (.clk(clk), .rst(rst), .disp(if_w));

  // Reference model: position in the scan timeline decides everything. The
  // frame shown in frame f is whatever game_display held during the last
  // blank cycle of row 0 of that frame.
  function automatic void model(input int r, input int b, input bit al, input int tt,
                                output logic [7:0] rs, output logic [7:0] cd,
                                output logic fd, output logic [2:0] sr);
    int p, f, pos, row, off, sidx;
    logic [63:0] frame;
    logic [7:0]  pat;
    p    = 8 * (b + r);
    f    = tt / p;
    pos  = tt % p;
    row  = pos / (b + r);
    off  = pos % (b + r);
    sr   = 3'(row);
    fd   = (pos == 0) && (f > 0);
    rs   = al ? 8'hFF : 8'h00;
    cd   = 8'h00;
    if (off >= b) begin
      sidx  = f * p + b - 1;
      frame = gd_hist[sidx];
      pat   = frame[row*8 +: 8];
      rs    = al ? ~(8'h01 << row) : (8'h01 << row);
`ifdef STACKER_SCAN_DIM_EN
      cd    = (((off - b) % 8) <= int'(br_hist[sidx])) ? pat : 8'h00;
`else
      cd    = pat;
`endif
    end
  endfunction

  task automatic drive(input logic [63:0] g, input logic [2:0] b);
    gd = g;
    br = b;
    if (t < 1024) begin
      gd_hist[t] = g;
      br_hist[t] = b;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    t = t + 1;
  endtask

  // Hold reset for two edges, release just after an edge; cycle 0 starts here.
  task automatic start_scan(input logic [63:0] g, input logic [2:0] b);
    rst = 1'b0;
    gd  = g;
    br  = b;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    t   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    gd  = 64'hDEAD_BEEF_0123_4567;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== 20'h0) begin
      errors++;
      $display("FAIL reset_a got rs=%h cd=%h fd=%b sr=%0d exp all zero",
               if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row);
    end
    checks++;
    if (if_l.row_sel !== 8'hFF || if_l.col_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_l got rs=%h cd=%h exp rs=ff cd=00", if_l.row_sel, if_l.col_data);
    end
  endtask

  task automatic test_scan_basic();
    logic [7:0] rs, cd;
    logic fd;
    logic [2:0] sr;
    start_scan(64'h8000_0000_0000_0001, 3'd0);
    for (int i = 0; i < 100; i++) begin
      drive(64'h8000_0000_0000_0001, 3'd0);
      @(negedge clk);
      model(4, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL basic_a t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row, rs, cd, fd, sr);
      end
      model(4, 2, 1'b1, t, rs, cd, fd, sr);
      checks++;
      if ({if_l.row_sel, if_l.col_data, if_l.frame_done} !== {rs, cd, fd}) begin
        errors++;
        $display("FAIL basic_l t=%0d got rs=%h cd=%h fd=%b exp rs=%h cd=%h fd=%b",
                 t, if_l.row_sel, if_l.col_data, if_l.frame_done, rs, cd, fd);
      end
      if (t == 1 || t == 2 || t == 9 || t == 45) begin
        checks++;
        if ({if_a.row_sel, if_a.col_data} !== ((t == 1) ? 16'h0000 : (t == 2) ? 16'h0101 :
                                               (t == 9) ? 16'h0200 : 16'h8080)) begin
          errors++;
          $display("FAIL basic_spot t=%0d got rs=%h cd=%h", t, if_a.row_sel, if_a.col_data);
        end
      end
      if (t == 3 || t == 46) begin
        checks++;
        if (if_l.row_sel !== ((t == 3) ? 8'hFE : 8'h7F)) begin
          errors++;
          $display("FAIL low_spot t=%0d got rs=%h exp %h", t, if_l.row_sel, (t == 3) ? 8'hFE : 8'h7F);
        end
      end
      if (t == 47 || t == 48 || t == 96) begin
        checks++;
        if (if_a.frame_done !== (t != 47)) begin
          errors++;
          $display("FAIL frame_done t=%0d got %b exp %b", t, if_a.frame_done, t != 47);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_tear_free();
    logic [7:0] rs, cd;
    logic fd;
    logic [2:0] sr;
    logic [63:0] g;
    start_scan('1, 3'd0);
    for (int i = 0; i < 100; i++) begin
      g = (t < 20) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      drive(g, 3'd0);
      @(negedge clk);
      model(4, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL tear_a t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row, rs, cd, fd, sr);
      end
      if (t == 22 || t == 44 || t == 50 || t == 92) begin
        checks++;
        if (if_a.col_data !== ((t < 48) ? 8'hFF : 8'h00)) begin
          errors++;
          $display("FAIL tear_spot t=%0d got cd=%h exp %h", t, if_a.col_data, (t < 48) ? 8'hFF : 8'h00);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rs, cd;
    logic fd;
    logic [2:0] sr;
    start_scan('1, 3'd0);
    for (int i = 0; i < 27; i++) begin
      drive('1, 3'd0);
      @(negedge clk);
      model(4, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_a.row_sel, if_a.col_data, if_a.scan_row} !== {rs, cd, sr}) begin
        errors++;
        $display("FAIL pre_reset t=%0d got rs=%h cd=%h sr=%0d exp rs=%h cd=%h sr=%0d",
                 t, if_a.row_sel, if_a.col_data, if_a.scan_row, rs, cd, sr);
      end
      next_cycle();
    end
    drive('1, 3'd0);
    #2;
    checks++;
    if (if_a.row_sel !== 8'h10 || if_a.col_data !== 8'hFF) begin
      errors++;
      $display("FAIL mid_before got rs=%h cd=%h exp rs=10 cd=ff", if_a.row_sel, if_a.col_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== 20'h0 ||
        if_l.row_sel !== 8'hFF) begin
      errors++;
      $display("FAIL mid_async got rs=%h cd=%h fd=%b sr=%0d lrs=%h exp 00 00 0 0 ff",
               if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row, if_l.row_sel);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    t   = 0;
    for (int i = 0; i < 20; i++) begin
      drive(64'h0123_4567_89AB_CDEF, 3'd0);
      @(negedge clk);
      model(4, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL restart t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row, rs, cd, fd, sr);
      end
      next_cycle();
    end
  endtask

  task automatic test_dim();
    logic [7:0] rs, cd, exp_cd;
    logic fd;
    logic [2:0] sr, b;
`ifdef STACKER_SCAN_DIM_EN
    logic [2:0] b0 = 3'd3;
`else
    logic [2:0] b0 = 3'd0;
`endif
    start_scan(64'hAA, b0);
    for (int i = 0; i < 162; i++) begin
      b = (t < 100) ? b0 : 3'd7;
      drive(64'h0000_0000_0000_00AA, b);
      @(negedge clk);
      model(16, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_w.row_sel, if_w.col_data, if_w.frame_done, if_w.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL dim_w t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_w.row_sel, if_w.col_data, if_w.frame_done, if_w.scan_row, rs, cd, fd, sr);
      end
      if ((t >= 2 && t <= 17) || (t >= 146 && t <= 161)) begin
`ifdef STACKER_SCAN_DIM_EN
        exp_cd = (t >= 146 || ((t - 2) % 8) <= 3) ? 8'hAA : 8'h00;
`else
        exp_cd = 8'hAA;
`endif
        checks++;
        if (if_w.col_data !== exp_cd) begin
          errors++;
          $display("FAIL dim_spot t=%0d got cd=%h exp %h", t, if_w.col_data, exp_cd);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [7:0] rs, cd;
    logic fd;
    logic [2:0] sr;
    logic [63:0] g;
    logic [2:0] b;
    g = {$urandom, $urandom};
    b = 3'($urandom_range(0, 7));
    start_scan(g, b);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) g = {$urandom, $urandom};
      b = 3'($urandom_range(0, 7));
      drive(g, b);
      @(negedge clk);
      model(4, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL rand_a t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_a.row_sel, if_a.col_data, if_a.frame_done, if_a.scan_row, rs, cd, fd, sr);
      end
      model(4, 2, 1'b1, t, rs, cd, fd, sr);
      checks++;
      if ({if_l.row_sel, if_l.col_data, if_l.frame_done, if_l.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL rand_l t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_l.row_sel, if_l.col_data, if_l.frame_done, if_l.scan_row, rs, cd, fd, sr);
      end
      model(16, 2, 1'b0, t, rs, cd, fd, sr);
      checks++;
      if ({if_w.row_sel, if_w.col_data, if_w.frame_done, if_w.scan_row} !== {rs, cd, fd, sr}) begin
        errors++;
        $display("FAIL rand_w t=%0d got rs=%h cd=%h fd=%b sr=%0d exp rs=%h cd=%h fd=%b sr=%0d",
                 t, if_w.row_sel, if_w.col_data, if_w.frame_done, if_w.scan_row, rs, cd, fd, sr);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_tear_free();
    test_reset_mid();
    test_dim();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
